instruction_fetch_controller: RTL and testbench
===============================================

// Module: instruction_fetch_controller
// PURPOSE
// - Sequences the multi-cycle 128-bit line fetch of the instruction memory and serves 32-bit words to the CPU fetch stage.
// - Holds one 16-byte line buffer. Same-line fetches hit with no stall; a line change drives the new line address, stalls the CPU for the memory latency, then fills the buffer.
// - Sits between the PC/fetch stage and the instruction memory; it is the only driver of the memory address.
// PARAMETERS
// - MEM_LATENCY  5  clock edges the line address is held stable before memLine is sampled (>=2)
// - CNT_W        4  width of the wait counter; must hold MEM_LATENCY
// PORTS
// - clock             input   1    single system clock, all state on posedge
// - reset             input   1    synchronous, active-high
// - fetchRequest      input   1    CPU requests the word at pcAddress this cycle
// - pcAddress         input   32   byte address, word aligned; bits [1:0] ignored
// - flush             input   1    invalidates the line buffer, aborts any fill in progress
// - memLine           input   128  line from memory; byte 0 at [127:120]
// - memAddress        output  32   line address to memory, {tag,4'b0}, registered
// - instruction       output  32   fetched word, registered
// - instructionValid  output  1    instruction is valid this cycle (1-cycle pulse per hit)
// - stall             output  1    combinational: fetchRequest & ~hit; CPU holds pcAddress while high
// BEHAVIOUR
// - Interface decision: one clock, `clock`. `reset` is synchronous and active-high.
// - Reset values: state=IDLE, lineValid=0, lineTag=0, lineBuf=0, memAddress=0, instruction=0, instructionValid=0, waitCount=0.
// - hit = lineValid & (state==IDLE) & (pcAddress[31:4]==lineTag).
// - Word select: pcAddress[3:2]. 0->[127:96], 1->[95:64], 2->[63:32], 3->[31:0].
// - IDLE state:
//   - fetchRequest & hit: at the next edge, instruction<=word and instructionValid<=1. Hit latency is 1 cycle.
//   - fetchRequest & ~hit: memAddress<={pcAddress[31:4],4'b0}, waitCount<=MEM_LATENCY, state<=WAIT, instructionValid<=0.
//   - No fetchRequest: instructionValid<=0.
// - WAIT state: instructionValid=0.
//   - Each edge with waitCount>1: decrement.
//   - Edge with waitCount==1: lineBuf<=memLine, lineTag<=memAddress[31:4], lineValid<=1, state<=IDLE.
//   - The still-held request then hits on the following cycle.
//   - Cold miss: MEM_LATENCY+1 stall cycles. instructionValid rises MEM_LATENCY+1 edges after the miss edge.
// - Tag change in WAIT (pcAddress[31:4]!=memAddress[31:4]): memAddress reloads, waitCount<=MEM_LATENCY, no fill occurs.
// - fetchRequest dropped in WAIT: the fill still completes.
// - Priority: reset > flush > miss/fill > hit.
//   - flush: lineValid<=0, state<=IDLE, instructionValid<=0. memAddress is unchanged.
//   - flush with fetchRequest in the same cycle: the request is treated as a miss on the next cycle (stall stays high).
// - Reset mid-WAIT: the fill is abandoned and all reset values are applied at that edge.
// - memAddress changes only on a miss edge in IDLE or on a tag reload in WAIT. It is stable for the entire wait.
// - Address wrap: a tag of 28'hFFFFFFF is legal. There is no line prefetch, so nothing increments past it.
// CONFIGURATION
// - IFETCH_STATS_EN defined: adds output ports hitCount[31:0] and missCount[31:0].
//   - Both reset to 0 and wrap modulo 2^32.
//   - hitCount increments on each hit edge.
//   - missCount increments on each IDLE->WAIT transition. Tag reloads in WAIT are not counted.
//   - flush clears neither counter.
// - IFETCH_STATS_EN undefined: the ports and counters do not exist. Behaviour is otherwise identical.
// TESTING
// - Memory model: MEM_LATENCY=5. Line 0 = 00430800,00A62001,01093802,016C5003. Line 1 = 01CF6804,02208007,16720004,1EB40015.
// - Reset: hold reset 2 cycles -> all outputs 0, stall=0 with fetchRequest=0.
// - Cold miss: fetchRequest=1, pc=0x0 -> memAddress=0x0; stall high 6 cycles; then instruction=0x00430800 with instructionValid=1.
// - Hit: then pc=0x4, 0x8, 0xC -> 00A62001, 01093802, 016C5003, one per cycle, stall=0 throughout.
// - Line change: pc=0x14 -> memAddress=0x10, stall 6 cycles, then 0x02208007. pc=0x1C next -> 0x1EB40015 with no stall.
// - Redirect mid-WAIT: pc=0x0 miss, pc changed to 0x10 on wait cycle 3 -> memAddress=0x10, 5-edge wait restarts, delivers 0x01CF6804; line 0 is never filled.
// - Flush and reset: flush after the line-0 fill, then pc=0x4 -> a full miss again. Reset asserted on wait cycle 2 -> lineValid=0 and IDLE; stats (if enabled) hit=0, miss=0.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// Single-line (16-byte) instruction buffer: serves 32-bit words on a hit, fetches a new line on a miss.
// Define IFETCH_STATS_EN to add the hitCount/missCount statistics ports.
module instruction_fetch_controller #(
  parameter int MEM_LATENCY = 5,
  parameter int CNT_W       = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         fetchRequest,
  input  logic [31:0]  pcAddress,
  input  logic         flush,
  input  logic [127:0] memLine,
  output logic [31:0]  memAddress,
  output logic [31:0]  instruction,
  output logic         instructionValid,
  output logic         stall
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]  hitCount,
  output logic [31:0]  missCount
`endif
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e         state_q, state_d;
  logic           line_valid_q, line_valid_d;
  logic [27:0]    line_tag_q, line_tag_d;
  logic [127:0]   line_buf_q, line_buf_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [31:0]    instr_q, instr_d;
  logic           instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`ifdef IFETCH_STATS_EN
  logic [31:0]    hit_cnt_q, hit_cnt_d;
  logic [31:0]    miss_cnt_q, miss_cnt_d;
`endif

  logic        hit;
  logic        hit_now;
  logic        miss_now;
  logic        tag_reload;
  logic [31:0] word_sel;
  logic [31:0] line_words [4];
  logic        unused_addr_bits;

  assign unused_addr_bits = &{1'b0, pcAddress[1:0]};

  // Byte 0 sits in the top byte, so word 0 is the most significant slice.
  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign line_words[gi] = line_buf_q[127-32*gi -: 32];
  end

  assign word_sel   = line_words[pcAddress[3:2]];
  assign hit        = line_valid_q & (state_q == IDLE) & (pcAddress[31:4] == line_tag_q);
  assign hit_now    = fetchRequest & hit;
  assign miss_now   = (state_q == IDLE) & fetchRequest & ~hit;
  assign tag_reload = (state_q == WAIT) & fetchRequest & (pcAddress[31:4] != mem_addr_q[31:4]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      line_valid_q  <= 1'b0;
      line_tag_q    <= '0;
      line_buf_q    <= '0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      wait_cnt_q    <= '0;
`ifdef IFETCH_STATS_EN
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      line_valid_q  <= line_valid_d;
      line_tag_q    <= line_tag_d;
      line_buf_q    <= line_buf_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      wait_cnt_q    <= wait_cnt_d;
`ifdef IFETCH_STATS_EN
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (miss_now) state_d = WAIT;
        WAIT: if (!tag_reload && wait_cnt_q <= CNT_W'(1)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    line_valid_d  = line_valid_q;
    line_tag_d    = line_tag_q;
    line_buf_d    = line_buf_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    if (flush) begin
      line_valid_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (hit_now) begin
        instr_d       = word_sel;
        instr_valid_d = 1'b1;
      end else if (miss_now) begin
        mem_addr_d = {pcAddress[31:4], 4'b0000};
        wait_cnt_d = CNT_W'(MEM_LATENCY);
      end
    end else begin
      // A redirected PC restarts the wait on the new line; the old line is never filled.
      if (tag_reload) begin
        mem_addr_d = {pcAddress[31:4], 4'b0000};
        wait_cnt_d = CNT_W'(MEM_LATENCY);
      end else if (wait_cnt_q > CNT_W'(1)) begin
        wait_cnt_d = wait_cnt_q - CNT_W'(1);
      end else begin
        line_buf_d   = memLine;
        line_tag_d   = mem_addr_q[31:4];
        line_valid_d = 1'b1;
      end
    end
  end

`ifdef IFETCH_STATS_EN
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (!flush && hit_now)  hit_cnt_d  = hit_cnt_q + 32'd1;
    if (!flush && miss_now) miss_cnt_d = miss_cnt_q + 32'd1;
  end
`endif

  always_comb begin
    memAddress       = mem_addr_q;
    instruction      = instr_q;
    instructionValid = instr_valid_q;
    stall            = fetchRequest & ~hit;
`ifdef IFETCH_STATS_EN
    hitCount         = hit_cnt_q;
    missCount        = miss_cnt_q;
`endif
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed literal checks plus randomized traffic against
// a deadline-based reference model (statistics ports are checked when IFETCH_STATS_EN is defined).
module tb_instruction_fetch_controller;
  localparam int L = 5;

  logic         clock = 1'b0;
  logic         reset, fetchRequest, flush;
  logic [31:0]  pcAddress;
  logic [127:0] memLine;
  logic [31:0]  memAddress, instruction;
  logic         instructionValid, stall;
`ifdef IFETCH_STATS_EN
  logic [31:0]  hitCount, missCount;
`endif

  always #5 clock = ~clock;

  instruction_fetch_controller #(.MEM_LATENCY(L), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .fetchRequest(fetchRequest), .pcAddress(pcAddress),
    .flush(flush), .memLine(memLine), .memAddress(memAddress), .instruction(instruction),
    .instructionValid(instructionValid), .stall(stall)
`ifdef IFETCH_STATS_EN
    , .hitCount(hitCount), .missCount(missCount)
`endif
  );

  function automatic logic [127:0] mem_line(input logic [27:0] tag);
    logic [31:0] h;
    h = {tag, 4'h0} ^ 32'hA5A5_3C3C;
    if (tag == 28'd0) return {32'h00430800, 32'h00A62001, 32'h01093802, 32'h016C5003};
    if (tag == 28'd1) return {32'h01CF6804, 32'h02208007, 32'h16720004, 32'h1EB40015};
    return {h, ~h, h * 32'd3, h ^ 32'h1234_5678};
  endfunction

  assign memLine = mem_line(memAddress[31:4]);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: a pending fill completes at an absolute edge index (deadline).
  bit          m_ready = 0;
  bit          m_lv, m_waiting, m_valid;
  logic [27:0] m_tag;
  logic [127:0] m_buf;
  logic [31:0] m_addr, m_instr, m_hits, m_misses;
  int          m_cyc = 0;
  int          m_deadline;

  always @(posedge clock) begin : model
    bit m_hit;
    m_hit = m_lv && !m_waiting && (pcAddress[31:4] == m_tag);
    if (reset) begin
      m_ready = 1; m_lv = 0; m_waiting = 0; m_valid = 0; m_tag = '0; m_buf = '0;
      m_addr = '0; m_instr = '0; m_hits = '0; m_misses = '0;
    end else if (flush) begin
      m_lv = 0; m_waiting = 0; m_valid = 0;
    end else if (!m_waiting) begin
      m_valid = 0;
      if (fetchRequest && m_hit) begin
        m_instr = m_buf[127 - 32*pcAddress[3:2] -: 32];
        m_valid = 1;
        m_hits  = m_hits + 1;
      end else if (fetchRequest) begin
        m_addr = {pcAddress[31:4], 4'h0};
        m_waiting = 1;
        m_deadline = m_cyc + L;
        m_misses = m_misses + 1;
      end
    end else begin
      m_valid = 0;
      if (fetchRequest && pcAddress[31:4] != m_addr[31:4]) begin
        m_addr = {pcAddress[31:4], 4'h0};
        m_deadline = m_cyc + L;
      end else if (m_cyc == m_deadline) begin
        m_buf = mem_line(m_addr[31:4]);
        m_tag = m_addr[31:4];
        m_lv = 1;
        m_waiting = 0;
      end
    end
    m_cyc++;
  end

  always @(negedge clock) begin
    if (m_ready) begin
      chk("memAddress", memAddress, m_addr);
      chk("instruction", instruction, m_instr);
      chk("instructionValid", {31'd0, instructionValid}, {31'd0, m_valid});
      chk("stall", {31'd0, stall},
          {31'd0, fetchRequest & ~(m_lv & ~m_waiting & (pcAddress[31:4] == m_tag))});
`ifdef IFETCH_STATS_EN
      chk("hitCount", hitCount, m_hits);
      chk("missCount", missCount, m_misses);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic r, input logic req, input logic [31:0] pc, input logic fl);
    reset = r; fetchRequest = req; pcAddress = pc; flush = fl;
    #1;
  endtask

  task automatic wait_fill(output int n);
    n = 0;
    while (stall === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    logic [31:0] hit_pcs [3];
    logic [31:0] hit_words [3];
    hit_pcs   = '{32'h4, 32'h8, 32'hC};
    hit_words = '{32'h00A62001, 32'h01093802, 32'h016C5003};

    reset = 1; fetchRequest = 0; pcAddress = 0; flush = 0;
    tick(); tick();
    set_in(0, 0, 32'h0, 0);
    chk("rst_memAddress", memAddress, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_valid", {31'd0, instructionValid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    set_in(0, 1, 32'h0, 0);
    chk("cold_stall", {31'd0, stall}, 32'd1);
    wait_fill(n);
    chk("cold_stall_cycles", 32'(n), 32'd6);
    chk("cold_memAddress", memAddress, 32'h0);
    tick();
    chk("cold_valid", {31'd0, instructionValid}, 32'd1);
    chk("cold_instr", instruction, 32'h00430800);

    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, hit_pcs[i], 0);
      chk("hit_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("hit_instr", instruction, hit_words[i]);
      chk("hit_valid", {31'd0, instructionValid}, 32'd1);
    end

    set_in(0, 1, 32'h14, 0);
    chk("lc_stall", {31'd0, stall}, 32'd1);
    wait_fill(n);
    chk("lc_stall_cycles", 32'(n), 32'd6);
    chk("lc_memAddress", memAddress, 32'h10);
    tick();
    chk("lc_instr", instruction, 32'h02208007);
    set_in(0, 1, 32'h1C, 0);
    chk("lc_hit_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("lc_hit_instr", instruction, 32'h1EB40015);

    set_in(0, 1, 32'h0, 0);
    tick();
    chk("rd_memAddress0", memAddress, 32'h0);
    tick(); tick();
    set_in(0, 1, 32'h10, 0);
    tick();
    chk("rd_memAddress1", memAddress, 32'h10);
    wait_fill(n);
    chk("rd_wait_cycles", 32'(n), 32'd5);
    tick();
    chk("rd_instr", instruction, 32'h01CF6804);
    set_in(0, 1, 32'h0, 0);
    chk("rd_line0_unfilled", {31'd0, stall}, 32'd1);
    wait_fill(n);
    chk("rd_line0_cycles", 32'(n), 32'd6);
    tick();
    chk("rd_line0_instr", instruction, 32'h00430800);

    set_in(0, 0, 32'h0, 1);
    tick();
    set_in(0, 1, 32'h4, 0);
    chk("fl_stall", {31'd0, stall}, 32'd1);
    wait_fill(n);
    chk("fl_stall_cycles", 32'(n), 32'd6);
    tick();
    chk("fl_instr", instruction, 32'h00A62001);

    set_in(0, 1, 32'h20, 0);
    tick();
    chk("rw_memAddress", memAddress, 32'h20);
    tick();
    set_in(1, 1, 32'h20, 0);
    tick();
    set_in(0, 0, 32'h20, 0);
    chk("rw_memAddress_rst", memAddress, 32'h0);
    chk("rw_instr_rst", instruction, 32'h0);
    chk("rw_valid_rst", {31'd0, instructionValid}, 32'd0);
    chk("rw_stall_rst", {31'd0, stall}, 32'd0);
`ifdef IFETCH_STATS_EN
    chk("rw_hitCount", hitCount, 32'd0);
    chk("rw_missCount", missCount, 32'd0);
`endif
    set_in(0, 1, 32'h0, 0);
    chk("rw_line_invalid", {31'd0, stall}, 32'd1);

    set_in(0, 1, 32'hFFFF_FFFC, 0);
    wait_fill(n);
    chk("wrap_stall_cycles", 32'(n), 32'd6);
    chk("wrap_memAddress", memAddress, 32'hFFFF_FFF0);
    tick();
    chk("wrap_instr", instruction, 32'h486E95B4);

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 39) == 0);
      fetchRequest = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        logic [27:0] t;
        case ($urandom_range(0, 4))
          0: t = 28'd0;
          1: t = 28'd1;
          2: t = 28'd2;
          3: t = 28'hFFFFFFF;
          default: t = 28'($urandom);
        endcase
        pcAddress = {t, 4'($urandom)};
      end
      tick();
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
